// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: FU class encoding and the issue-queue
// entry layout used by the issue scheduler and the load/store queues.
package ooo_pkg;

   // Functional-unit class carried in fu_sel; doubles as the fu_busy bit index.
   localparam logic [2:0] FU_ALU   = 3'd0;  // alu / csr
   localparam logic [2:0] FU_MUL   = 3'd1;
   localparam logic [2:0] FU_DIV   = 3'd2;
   localparam logic [2:0] FU_FALU  = 3'd3;
   localparam logic [2:0] FU_FMUL  = 3'd4;
   localparam logic [2:0] FU_FDIV  = 3'd5;
   localparam logic [2:0] FU_LOAD  = 3'd6;
   localparam logic [2:0] FU_STORE = 3'd7;

   // Field widths of a queue entry; the scheduler's width parameters default to these.
   localparam int IQ_PREG_W    = 7;
   localparam int IQ_ROB_W     = 3;
   localparam int IQ_PAYLOAD_W = 64;

   typedef struct packed {
      logic                    valid;
      logic [2:0]              fu_sel;
      logic [IQ_PREG_W-1:0]    P_rs1;
      logic                    rs1_rdy;
      logic [IQ_PREG_W-1:0]    P_rs2;
      logic                    rs2_rdy;
      logic [IQ_PREG_W-1:0]    P_rd;
      logic [IQ_ROB_W-1:0]     rob_idx;
      logic [IQ_PAYLOAD_W-1:0] payload;
   } iq_entry_t;

endpackage

// File: rtl/iq_age_picker.sv
// Oldest-first picker: given an eligible vector and an age matrix
// (age[i][j]=1 means entry i is older than entry j), grants the eligible
// entry that no other eligible entry is older than.
module iq_age_picker #(
   parameter int DEPTH = 8
) (
   input  logic [DEPTH-1:0]         eligible,
   input  logic [DEPTH-1:0]         age [DEPTH],
   output logic [DEPTH-1:0]         grant,
   output logic [$clog2(DEPTH)-1:0] idx,
   output logic                     any
);

   localparam int IDX_W = $clog2(DEPTH);

   // Grant each eligible entry unless some other eligible entry is older.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      grant = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant[i] = eligible[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (eligible[j] && age[j][i]) grant[i] = 1'b0;
         end
      end
   end

   // Encode the one-hot grant into a slot index.
   always_comb begin
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) idx = IDX_W'(i);
      end
   end

   assign any = |eligible;

endmodule

// File: rtl/issue_sched.sv
// Unified issue queue: buffers renamed uops, wakes sources from the writeback
// tag bus, and issues the oldest ready uop whose FU class is free.
module issue_sched
   import ooo_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int PREG_W    = IQ_PREG_W,
   parameter int ROB_W     = IQ_ROB_W,
   parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_fu_sel,
   input  logic [PREG_W-1:0]        in_P_rs1,
   input  logic [PREG_W-1:0]        in_P_rs2,
   input  logic                     in_rs1_rdy,
   input  logic                     in_rs2_rdy,
   input  logic [PREG_W-1:0]        in_P_rd,
   input  logic [ROB_W-1:0]         in_rob_idx,
   input  logic [PAYLOAD_W-1:0]     in_payload,
   input  logic                     wb_valid,
   input  logic [PREG_W-1:0]        wb_P_rd,
   input  logic [7:0]               fu_busy,
   output logic                     iss_valid,
   input  logic                     iss_ready,
   output logic [2:0]               iss_fu_sel,
   output logic [PREG_W-1:0]        iss_P_rs1,
   output logic [PREG_W-1:0]        iss_P_rs2,
   output logic [PREG_W-1:0]        iss_P_rd,
   output logic [ROB_W-1:0]         iss_rob_idx,
   output logic [PAYLOAD_W-1:0]     iss_payload,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     mispredict
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   iq_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] age     [DEPTH];
   logic [DEPTH-1:0] eligible;
   logic [DEPTH-1:0] grant;
   logic [IDX_W-1:0] iss_idx;
   logic [IDX_W-1:0] alloc_idx;
   logic             any_eligible;
   logic             alloc;
   logic             iss_fire;
   logic             alloc_rs1_rdy;
   logic             alloc_rs2_rdy;

   assign in_ready  = (count < CNT_W'(DEPTH)) && !mispredict;
   assign alloc     = in_valid && in_ready;
   assign iss_valid = any_eligible && !mispredict;
   assign iss_fire  = iss_valid && iss_ready;

   // Tag 0 is hard-wired ready; a same-cycle broadcast is captured at allocation.
   assign alloc_rs1_rdy = in_rs1_rdy || (in_P_rs1 == '0) || (wb_valid && (wb_P_rd == in_P_rs1));
   assign alloc_rs2_rdy = in_rs2_rdy || (in_P_rs2 == '0) || (wb_valid && (wb_P_rd == in_P_rs2));

   // An entry may issue once both sources are ready and its FU class is idle.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < DEPTH; i++) begin
         eligible[i] = entries[i].valid && entries[i].rs1_rdy && entries[i].rs2_rdy
                       && !fu_busy[entries[i].fu_sel];
      end
   end

   // New uops go to the lowest-index free slot; the slot being issued is still valid here.
   always_comb begin
      alloc_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!entries[i].valid) alloc_idx = IDX_W'(i);
      end
   end

   iq_age_picker #(.DEPTH(DEPTH)) u_picker (
      .eligible (eligible),
      .age      (age),
      .grant    (grant),
      .idx      (iss_idx),
      .any      (any_eligible)
   );

   assign iss_fu_sel  = entries[iss_idx].fu_sel;
   assign iss_P_rs1   = entries[iss_idx].P_rs1;
   assign iss_P_rs2   = entries[iss_idx].P_rs2;
   assign iss_P_rd    = entries[iss_idx].P_rd;
   assign iss_rob_idx = entries[iss_idx].rob_idx;
   assign iss_payload = entries[iss_idx].payload;

   // Queue state: wakeup, issue release, allocation, age ordering and occupancy.
   always_ff @(posedge clk) begin
      // NOTE: state is written with <= so every update in this block sees pre-edge values.
      if (rst || mispredict) begin
         // NOTE: only valid bits are reset; tag and payload storage is don't-care while invalid.
         for (int i = 0; i < DEPTH; i++) begin
            entries[i].valid <= 1'b0;
            age[i]           <= '0;
         end
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && wb_valid) begin
               if (wb_P_rd == entries[i].P_rs1) entries[i].rs1_rdy <= 1'b1;
               if (wb_P_rd == entries[i].P_rs2) entries[i].rs2_rdy <= 1'b1;
            end
            if (iss_fire && grant[i]) entries[i].valid <= 1'b0;
         end
         if (alloc) begin
            entries[alloc_idx] <= '{valid:   1'b1,
                                    fu_sel:  in_fu_sel,
                                    P_rs1:   in_P_rs1,
                                    rs1_rdy: alloc_rs1_rdy,
                                    P_rs2:   in_P_rs2,
                                    rs2_rdy: alloc_rs2_rdy,
                                    P_rd:    in_P_rd,
                                    rob_idx: in_rob_idx,
                                    payload: in_payload};
            age[alloc_idx] <= '0;
            for (int j = 0; j < DEPTH; j++) begin
               if (entries[j].valid) age[j][alloc_idx] <= 1'b1;
            end
         end
         count <= count + CNT_W'(alloc) - CNT_W'(iss_fire);
      end
   end

endmodule

// File: tb/tb_issue_sched.sv
// Self-checking bench for issue_sched: directed scenarios followed by a random
// phase, all compared every cycle against an age-ordered queue model.
module tb_issue_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_fu_sel;
   logic [6:0]   in_P_rs1, in_P_rs2, in_P_rd;
   logic         in_rs1_rdy, in_rs2_rdy;
   logic [2:0]   in_rob_idx;
   logic [63:0]  in_payload;
   logic         wb_valid;
   logic [6:0]   wb_P_rd;
   logic [7:0]   fu_busy;
   logic         iss_valid;
   logic         iss_ready;
   logic [2:0]   iss_fu_sel;
   logic [6:0]   iss_P_rs1, iss_P_rs2, iss_P_rd;
   logic [2:0]   iss_rob_idx;
   logic [63:0]  iss_payload;
   logic [3:0]   count;
   logic         mispredict;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   issue_sched dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_fu_sel(in_fu_sel),
      .in_P_rs1(in_P_rs1), .in_P_rs2(in_P_rs2), .in_rs1_rdy(in_rs1_rdy),
      .in_rs2_rdy(in_rs2_rdy), .in_P_rd(in_P_rd), .in_rob_idx(in_rob_idx),
      .in_payload(in_payload), .wb_valid(wb_valid), .wb_P_rd(wb_P_rd),
      .fu_busy(fu_busy), .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_fu_sel(iss_fu_sel), .iss_P_rs1(iss_P_rs1), .iss_P_rs2(iss_P_rs2),
      .iss_P_rd(iss_P_rd), .iss_rob_idx(iss_rob_idx), .iss_payload(iss_payload),
      .count(count), .mispredict(mispredict)
   );

   // Reference model: queued uops kept oldest-first.
   typedef struct {
      logic [2:0]  fu;
      logic [6:0]  rs1, rs2, rd;
      bit          r1, r2;
      logic [2:0]  rob;
      logic [63:0] pay;
   } uop_t;

   uop_t q[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      in_valid = 0; in_fu_sel = 0; in_P_rs1 = 0; in_P_rs2 = 0; in_rs1_rdy = 0;
      in_rs2_rdy = 0; in_P_rd = 0; in_rob_idx = 0; in_payload = 0;
      wb_valid = 0; wb_P_rd = 0;
   endtask

   task automatic disp(input logic [2:0] fu, input logic [6:0] rs1, input bit r1,
                       input logic [6:0] rs2, input bit r2, input logic [6:0] rd,
                       input logic [2:0] rob);
      in_valid = 1; in_fu_sel = fu; in_P_rs1 = rs1; in_rs1_rdy = r1;
      in_P_rs2 = rs2; in_rs2_rdy = r2; in_P_rd = rd; in_rob_idx = rob;
      in_payload = {$urandom, $urandom};
   endtask

   // One clock: compare outputs mid-cycle against the model, then advance the model.
   task automatic cycle();
      bit   exp_rdy, exp_iv;
      int   pick;
      uop_t u;
      @(negedge clk);
      exp_rdy = (q.size() < 8) && !mispredict;
      pick = -1;
      for (int k = 0; k < q.size(); k++) begin
         if (pick < 0 && q[k].r1 && q[k].r2 && !fu_busy[q[k].fu]) pick = k;
      end
      exp_iv = (pick >= 0) && !mispredict;
      check("in_ready", 128'(in_ready), 128'(exp_rdy));
      check("iss_valid", 128'(iss_valid), 128'(exp_iv));
      check("count", 128'(count), 128'(q.size()));
      if (exp_iv)
         check("iss_fields",
               128'({iss_fu_sel, iss_P_rs1, iss_P_rs2, iss_P_rd, iss_rob_idx, iss_payload}),
               128'({q[pick].fu, q[pick].rs1, q[pick].rs2, q[pick].rd, q[pick].rob, q[pick].pay}));
      if (rst || mispredict) begin
         q.delete();
      end else begin
         for (int k = 0; k < q.size(); k++) begin
            if (wb_valid && wb_P_rd == q[k].rs1) q[k].r1 = 1;
            if (wb_valid && wb_P_rd == q[k].rs2) q[k].r2 = 1;
         end
         if (exp_iv && iss_ready) q.delete(pick);
         if (in_valid && exp_rdy) begin
            u.fu = in_fu_sel; u.rs1 = in_P_rs1; u.rs2 = in_P_rs2; u.rd = in_P_rd;
            u.rob = in_rob_idx; u.pay = in_payload;
            u.r1 = in_rs1_rdy || in_P_rs1 == 0 || (wb_valid && wb_P_rd == in_P_rs1);
            u.r2 = in_rs2_rdy || in_P_rs2 == 0 || (wb_valid && wb_P_rd == in_P_rs2);
            q.push_back(u);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1; mispredict = 0; fu_busy = 0; iss_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      q.delete();

      // Reset state.
      cycle();

      // A: all-ready ALU uop issues the cycle after dispatch.
      disp(3'd0, 7'd0, 0, 7'd0, 0, 7'd20, 3'd1); cycle();
      idle(); cycle(); cycle();

      // B waits on p9; younger ready C overtakes; wakeup is visible one cycle later.
      disp(3'd0, 7'd9, 0, 7'd0, 1, 7'd21, 3'd2); cycle();
      disp(3'd0, 7'd3, 1, 7'd4, 1, 7'd22, 3'd3); cycle();
      idle(); cycle(); cycle();
      wb_valid = 1; wb_P_rd = 7'd9; cycle();
      idle(); cycle(); cycle();

      // D then E on a busy multiplier: held, then issued in age order.
      fu_busy = 8'h02;
      disp(3'd1, 7'd0, 1, 7'd0, 1, 7'd23, 3'd4); cycle();
      disp(3'd1, 7'd0, 1, 7'd0, 1, 7'd24, 3'd5); cycle();
      idle(); repeat (3) cycle();
      fu_busy = 8'h00; repeat (3) cycle();

      // Fill the queue, free one slot, refill it.
      iss_ready = 0;
      for (int k = 0; k < 8; k++) begin
         disp(3'(k), 7'd0, 1, 7'd0, 1, 7'(30 + k), 3'(k)); cycle();
      end
      disp(3'd0, 7'd0, 1, 7'd0, 1, 7'd40, 3'd6); cycle();
      iss_ready = 1; cycle();
      iss_ready = 0; cycle();
      idle(); cycle();
      iss_ready = 1; repeat (10) cycle();

      // Flush with five queued entries while a dispatch is held.
      iss_ready = 0;
      for (int k = 0; k < 5; k++) begin
         disp(3'd0, 7'd0, 1, 7'd0, 1, 7'(50 + k), 3'(k)); cycle();
      end
      mispredict = 1; cycle();
      mispredict = 0; idle(); iss_ready = 1; cycle(); cycle();

      // F captures a same-cycle writeback of its source at allocation.
      disp(3'd6, 7'd12, 0, 7'd0, 1, 7'd60, 3'd7);
      wb_valid = 1; wb_P_rd = 7'd12; cycle();
      idle(); cycle(); cycle();

      // Random phase.
      for (int n = 0; n < 600; n++) begin
         idle();
         if ($urandom_range(0, 3) != 0)
            disp(3'($urandom_range(0, 7)), 7'($urandom_range(0, 12)), bit'($urandom_range(0, 1)),
                 7'($urandom_range(0, 12)), bit'($urandom_range(0, 1)),
                 7'($urandom_range(1, 127)), 3'($urandom));
         wb_valid   = bit'($urandom_range(0, 1));
         wb_P_rd    = 7'($urandom_range(0, 12));
         fu_busy    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         iss_ready  = ($urandom_range(0, 3) != 0);
         mispredict = ($urandom_range(0, 60) == 0);
         rst        = ($urandom_range(0, 150) == 0);
         cycle();
      end
      rst = 0; mispredict = 0; idle(); fu_busy = 0; iss_ready = 1;
      repeat (12) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
